// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// and loads the IF/ID register, holding words across stalls and dropping stale responses.
module if_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [WIDTH-1:0] i_imem_rdata,
  input  logic             i_stall,
  input  logic             i_id_flush,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-1:0] o_id_instr,
  output logic [WIDTH-1:0] o_id_pc,
  output logic [WIDTH-1:0] o_id_pc_plus4,
  output logic             o_id_valid
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DISCARD, S_HOLD} state_t;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] saved_pc_reg, saved_pc_next;
  logic [WIDTH-1:0] buf_instr_reg, buf_instr_next;
  logic [WIDTH-1:0] buf_pc_reg, buf_pc_next;
  logic [WIDTH-1:0] id_instr_reg, id_pc_reg, id_pc_plus4_reg;
  logic             id_valid_reg;

  logic             id_load, id_bubble;
  logic [WIDTH-1:0] id_src_instr, id_src_pc;
  logic [WIDTH-1:0] pc_plus4, redirect_pc_al;

  assign pc_plus4       = pc_reg + FOUR;
  assign redirect_pc_al = {i_redirect_pc[WIDTH-1:2], 2'b00};

  // Address is the PC itself; the FSM never moves the PC while a request is unacknowledged.
  assign o_imem_req    = ((state_reg == S_FETCH) || (state_reg == S_DISCARD)) && !i_rst;
  assign o_imem_addr   = pc_reg;
  assign o_id_instr    = id_instr_reg;
  assign o_id_pc       = id_pc_reg;
  assign o_id_pc_plus4 = id_pc_plus4_reg;
  assign o_id_valid    = id_valid_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    saved_pc_next  = saved_pc_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    id_load        = 1'b0;
    id_bubble      = 1'b0;
    id_src_instr   = i_imem_rdata;
    id_src_pc      = pc_reg;
    case (state_reg)
      S_IDLE: begin
        state_next = S_FETCH;
        id_bubble  = !i_stall;
        if (i_redirect) pc_next = redirect_pc_al;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          if (i_redirect) begin
            pc_next   = redirect_pc_al;
            id_bubble = !i_stall;
          end else if (!i_stall) begin
            id_load = 1'b1;
            pc_next = pc_plus4;
          end else begin
            buf_instr_next = i_imem_rdata;
            buf_pc_next    = pc_reg;
            pc_next        = pc_plus4;
            state_next     = S_HOLD;
          end
        end else if (i_redirect) begin
          // Request stays up at the stale address until memory answers.
          saved_pc_next = redirect_pc_al;
          state_next    = S_DISCARD;
          id_bubble     = !i_stall;
        end else begin
          id_bubble = !i_stall;
        end
      end
      S_DISCARD: begin
        id_bubble = !i_stall;
        if (i_redirect) saved_pc_next = redirect_pc_al;
        if (i_imem_ack) begin
          pc_next    = i_redirect ? redirect_pc_al : saved_pc_reg;
          state_next = S_FETCH;
        end
      end
      S_HOLD: begin
        if (i_redirect) begin
          pc_next    = redirect_pc_al;
          state_next = S_FETCH;
          id_bubble  = !i_stall;
        end else if (!i_stall) begin
          id_load      = 1'b1;
          id_src_instr = buf_instr_reg;
          id_src_pc    = buf_pc_reg;
          state_next   = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC;
      saved_pc_reg  <= '0;
      buf_instr_reg <= '0;
      buf_pc_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      saved_pc_reg  <= saved_pc_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
    end
  end

  // IF/ID priority: flush, then stall (hold), then load or bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      id_instr_reg    <= NOP_INSTR;
      id_pc_reg       <= '0;
      id_pc_plus4_reg <= '0;
      id_valid_reg    <= 1'b0;
    end else if (i_id_flush || (id_bubble && !id_load)) begin
      id_instr_reg    <= NOP_INSTR;
      id_pc_reg       <= '0;
      id_pc_plus4_reg <= '0;
      id_valid_reg    <= 1'b0;
    end else if (i_stall) begin
      id_instr_reg    <= id_instr_reg;
    end else if (id_load) begin
      id_instr_reg    <= id_src_instr;
      id_pc_reg       <= id_src_pc;
      id_pc_plus4_reg <= id_src_pc + FOUR;
      id_valid_reg    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] id_instr, id_pc, id_pc_plus4;
    logic        id_valid;
    int          tests = 0;
    int          fails = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    if_stage dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .i_stall      (stall),
        .i_id_flush   (flush),
        .i_redirect   (redir),
        .i_redirect_pc(redir_pc),
        .o_id_instr   (id_instr),
        .o_id_pc      (id_pc),
        .o_id_pc_plus4(id_pc_plus4),
        .o_id_valid   (id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic ack, input logic st, input logic fl,
                       input logic rd, input logic [31:0] rpc);
        imem_ack   = ack;
        stall      = st;
        flush      = fl;
        redir      = rd;
        redir_pc   = rpc;
        imem_rdata = word(imem_addr);
        @(posedge clk);
        @(negedge clk);
        $display("[TB] t=%0t ack=%b stall=%b flush=%b redir=%b -> req=%b addr=%h id_pc=%h id_instr=%h valid=%b",
                 $time, ack, st, fl, rd, imem_req, imem_addr, id_pc, id_instr, id_valid);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc4", id_pc_plus4, 32'h0);
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_req", imem_req, 1'b0);
        cyc(0, 0, 0, 0, 0);
        chk("fetch0_req", imem_req, 1'b1);
        chk("fetch0_addr", imem_addr, 32'h0);

        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 0, 0, 0);
            chk("zw_pc", id_pc, 32'(4 * k));
            chk("zw_pc4", id_pc_plus4, 32'(4 * k + 4));
            chk("zw_instr", id_instr, word(32'(4 * k)));
            chk("zw_valid", id_valid, 1'b1);
            chk("zw_addr", imem_addr, 32'(4 * k + 4));
        end

        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0);
            chk("wait_addr", imem_addr, 32'hC);
            chk("wait_req", imem_req, 1'b1);
            chk("wait_valid", id_valid, 1'b0);
            chk("wait_instr", id_instr, NOP);
        end
        cyc(1, 0, 0, 0, 0);
        chk("late_pc", id_pc, 32'hC);
        chk("late_instr", id_instr, word(32'hC));
        chk("late_valid", id_valid, 1'b1);
        chk("late_addr", imem_addr, 32'h10);

        cyc(1, 1, 0, 0, 0);
        chk("hold_req", imem_req, 1'b0);
        chk("hold_pc", id_pc, 32'hC);
        chk("hold_addr", imem_addr, 32'h14);
        cyc(0, 1, 0, 0, 0);
        chk("hold2_req", imem_req, 1'b0);
        chk("hold2_pc", id_pc, 32'hC);
        chk("hold2_valid", id_valid, 1'b1);
        cyc(0, 0, 0, 0, 0);
        chk("rel_pc", id_pc, 32'h10);
        chk("rel_instr", id_instr, word(32'h10));
        chk("rel_valid", id_valid, 1'b1);
        chk("rel_req", imem_req, 1'b1);
        chk("rel_addr", imem_addr, 32'h14);

        cyc(0, 0, 0, 1, 32'h180);
        chk("disc_addr", imem_addr, 32'h14);
        chk("disc_req", imem_req, 1'b1);
        cyc(0, 0, 0, 0, 0);
        chk("disc2_addr", imem_addr, 32'h14);
        cyc(0, 0, 0, 1, 32'h103);
        chk("disc3_addr", imem_addr, 32'h14);
        cyc(1, 0, 0, 0, 0);
        chk("disc_drop_valid", id_valid, 1'b0);
        chk("disc_new_addr", imem_addr, 32'h100);
        chk("disc_new_req", imem_req, 1'b1);

        cyc(1, 0, 0, 0, 0);
        chk("r100_pc", id_pc, 32'h100);
        chk("r100_instr", id_instr, word(32'h100));
        cyc(1, 1, 0, 0, 0);
        chk("h2_req", imem_req, 1'b0);
        chk("h2_pc", id_pc, 32'h100);
        cyc(0, 1, 1, 1, 32'h200);
        chk("fl_valid", id_valid, 1'b0);
        chk("fl_instr", id_instr, NOP);
        chk("fl_pc", id_pc, 32'h0);
        chk("fl_addr", imem_addr, 32'h200);
        chk("fl_req", imem_req, 1'b1);
        cyc(1, 0, 0, 0, 0);
        chk("r200_pc", id_pc, 32'h200);
        chk("r200_instr", id_instr, word(32'h200));

        cyc(1, 0, 0, 1, 32'hFFFF_FFFC);
        chk("ackrd_valid", id_valid, 1'b0);
        chk("ackrd_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0);
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        cyc(1, 0, 1, 0, 0);
        chk("flack_valid", id_valid, 1'b0);
        chk("flack_addr", imem_addr, 32'h4);

        cyc(0, 0, 0, 0, 0);
        chk("pre_rst_req", imem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("mrst_req", imem_req, 1'b0);
        chk("mrst_addr", imem_addr, 32'h0);
        chk("mrst_instr", id_instr, NOP);
        chk("mrst_valid", id_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_idle_req", imem_req, 1'b0);
        cyc(0, 0, 0, 0, 0);
        chk("mrst_fetch_req", imem_req, 1'b1);
        chk("mrst_fetch_addr", imem_addr, 32'h0);
        cyc(1, 0, 0, 0, 0);
        chk("mrst_first_pc", id_pc, 32'h0);
        chk("mrst_first_valid", id_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
